vip_playback_src: RTL and testbench

Single-clock AXI-Stream playback source: the read-side counterpart of the capture VIP. A host or testbench loads SAMP words into an internal RAM through a simple write port; on `start`, the block replays them in address order as an AXI-Stream master, with full throughput and `tlast` at frame boundaries. It sits in front of the ADC-domain FIFO or the OSPFB front end and replaces the free-running ADC model when deterministic, file-derived stimulus is required.

---
 rtl/vip_playback_src.sv | 162 ++++++++++++++++
 tb/tb_vip_playback_src.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_playback_src.sv
// AXI-Stream playback source: replays a host-loaded sample RAM in address order.
// Define VIP_PLAYBACK_LOOP_EN for endless replay; otherwise a single pass ends in DONE.
module vip_playback_src #(
  parameter int SAMP        = 256,
  parameter int TDATA_WIDTH = 16,
  parameter int FRAME_LEN   = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [$clog2(SAMP)-1:0] wr_addr,
  input  logic [TDATA_WIDTH-1:0]  wr_data,
  input  logic                    start,
  output logic [TDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_err,
  output logic [$clog2(SAMP):0]   xfer_count
);
  localparam int AW = $clog2(SAMP);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_XFER  = CW'(SAMP - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAME_LEN - 1);
`ifndef VIP_PLAYBACK_LOOP_EN
  localparam logic [AW-1:0] LAST_ADDR  = AW'(SAMP - 1);
`endif

  generate
    if ((SAMP < 2) || ((SAMP & (SAMP - 1)) != 0)) begin : g_bad_samp
      $error("vip_playback_src: SAMP must be a power of two >= 2");
    end
    if ((SAMP % FRAME_LEN) != 0) begin : g_bad_frame
      $error("vip_playback_src: SAMP must be a multiple of FRAME_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

  state_t                 state_reg, state_next;
  logic                   load_ok;
  logic [TDATA_WIDTH-1:0] ram [SAMP];
  logic [TDATA_WIDTH-1:0] ram_q;
  logic [AW-1:0]          rd_ptr_reg;
  logic                   rd_pend_reg;
  logic                   rd_done_reg;
  logic [TDATA_WIDTH-1:0] out_data_reg, skid_data_reg;
  logic                   out_v_reg, skid_v_reg;
  logic [FW-1:0]          frame_cnt_reg;
  logic [CW-1:0]          xfer_cnt_reg;
  logic                   wr_err_reg;
  logic                   pop, rd_issue, at_last_xfer, start_ok;
  logic [1:0]             occ;

  // occ counts buffered samples plus the read in flight; it never exceeds the two skid slots.
  assign pop          = out_v_reg && m_axis_tready;
  assign occ          = {1'b0, out_v_reg} + {1'b0, skid_v_reg} + {1'b0, rd_pend_reg};
  assign rd_issue     = busy && !rd_done_reg && ((occ < 2'd2) || pop);
  assign at_last_xfer = (xfer_cnt_reg == LAST_XFER);
  assign start_ok     = start && load_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_PRIME;
      S_PRIME:  if (rd_ptr_reg == AW'(1)) state_next = S_STREAM;
      S_STREAM: begin
`ifndef VIP_PLAYBACK_LOOP_EN
        if (pop && at_last_xfer) state_next = S_DONE;
`endif
      end
      S_DONE:   if (start) state_next = S_PRIME;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    load_ok = 1'b0;
    case (state_reg)
      S_IDLE:   load_ok = 1'b1;
      S_PRIME:  busy    = 1'b1;
      S_STREAM: busy    = 1'b1;
      S_DONE:   begin done = 1'b1; load_ok = 1'b1; end
      default:  load_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && load_ok) ram[wr_addr] <= wr_data;
    if (rd_issue)         ram_q <= ram[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_reg    <= '0;
      rd_pend_reg   <= 1'b0;
      rd_done_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_v_reg     <= 1'b0;
      skid_data_reg <= '0;
      skid_v_reg    <= 1'b0;
      frame_cnt_reg <= '0;
      xfer_cnt_reg  <= '0;
      wr_err_reg    <= 1'b0;
    end else begin
      wr_err_reg  <= wr_en && busy;
      rd_pend_reg <= rd_issue;
      if (start_ok) begin
        rd_ptr_reg    <= '0;
        rd_done_reg   <= 1'b0;
        frame_cnt_reg <= '0;
        xfer_cnt_reg  <= '0;
      end else begin
        if (rd_issue) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
`ifndef VIP_PLAYBACK_LOOP_EN
          if (rd_ptr_reg == LAST_ADDR) rd_done_reg <= 1'b1;
`endif
        end
        if (pop) begin
          frame_cnt_reg <= (frame_cnt_reg == LAST_FRAME) ? '0 : frame_cnt_reg + FW'(1);
`ifdef VIP_PLAYBACK_LOOP_EN
          xfer_cnt_reg  <= at_last_xfer ? '0 : xfer_cnt_reg + CW'(1);
`else
          xfer_cnt_reg  <= xfer_cnt_reg + CW'(1);
`endif
        end
      end
      // Oldest sample first: output register, then skid slot, then the landing RAM word.
      if (!out_v_reg || pop) begin
        if (skid_v_reg) begin
          out_data_reg <= skid_data_reg;
          out_v_reg    <= 1'b1;
          skid_v_reg   <= rd_pend_reg;
          if (rd_pend_reg) skid_data_reg <= ram_q;
        end else begin
          out_v_reg <= rd_pend_reg;
          if (rd_pend_reg) out_data_reg <= ram_q;
        end
      end else if (rd_pend_reg) begin
        skid_data_reg <= ram_q;
        skid_v_reg    <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_v_reg;
  assign m_axis_tlast  = out_v_reg && (frame_cnt_reg == LAST_FRAME);
  assign wr_err        = wr_err_reg;
  assign xfer_count    = xfer_cnt_reg;
endmodule

// File: tb/tb_vip_playback_src.sv
// Self-checking bench for vip_playback_src: cycle table, scoreboarded passes, reset and loop cases.
module tb_vip_playback_src;
  localparam int SAMP = 256;
  localparam int TW   = 16;
  localparam int FL   = 32;
  localparam int AW   = $clog2(SAMP);

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] wr_data;
  logic          start;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy, done, wr_err;
  logic [AW:0]   xfer_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [TW-1:0] exp_mem [SAMP];

  vip_playback_src #(.SAMP(SAMP), .TDATA_WIDTH(TW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
    .done(done), .wr_err(wr_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int st; int rdy; int wr;
    int v; int d; int l; int b; int dn; int e; int x;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wr_err"}, 32'(wr_err), 0);
    check({tag, "_xfer"}, 32'(xfer_count), 0);
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic async_reset(input string tag);
    rstn = 1'b0;
    #1;
    check_all_zero(tag);
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic load_ram(input bit ramp);
    for (int i = 0; i < SAMP; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = ramp ? TW'(i) : TW'($urandom);
      exp_mem[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
    check("load_wr_err", 32'(wr_err), 0);
    $display("load ram %s", ramp ? "ramp" : "random");
  endtask

  task automatic write_one(input int addr, input logic [TW-1:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    exp_mem[addr] = data;
    tick();
    wr_en = 1'b0;
    check("idle_wr_err", 32'(wr_err), 0);
    $display("write addr %0d data %04h", addr, data);
  endtask

  // One playback pass scoreboarded against exp_mem. wr_at/start_at inject a blocked
  // write or an ignored start on that cycle; abort_at resets after that many handshakes.
  task automatic run_pass(input int duty, input int wr_at, input int start_at, input int abort_at);
    int cyc, idx, first_v;
    bit seen_last, stall, wr_prev, finished;
    logic [TW-1:0] hold_d;
    logic hold_l;
    cyc = 0; idx = 0; first_v = -1;
    seen_last = 0; stall = 0; wr_prev = 0; finished = 0;
    hold_d = '0; hold_l = 1'b0;
    start = 1'b1; m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 8 * SAMP + 20) begin
      if (stall) begin
        check("stall_tvalid", 32'(m_axis_tvalid), 1);
        check("stall_tdata", 32'(m_axis_tdata), 32'(hold_d));
        check("stall_tlast", 32'(m_axis_tlast), 32'(hold_l));
      end
      check("wr_err", 32'(wr_err), 32'(wr_prev));
      if (seen_last) begin
        check("end_done", 32'(done), 1);
        check("end_tvalid", 32'(m_axis_tvalid), 0);
        check("end_busy", 32'(busy), 0);
        check("end_xfer", 32'(xfer_count), SAMP);
        check("end_count", idx, SAMP);
        if (duty == 100) check("end_latency", cyc, SAMP + 2);
        finished = 1;
        break;
      end
      check("run_done", 32'(done), 0);
      check("run_busy", 32'(busy), 1);
      m_axis_tready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      wr_en   = (cyc == wr_at);
      wr_addr = AW'(5);
      wr_data = 16'hBEEF;
      start   = (cyc == start_at);
      if (m_axis_tvalid && first_v < 0) begin
        first_v = cyc;
        check("first_valid_cyc", cyc, 2);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("tdata", 32'(m_axis_tdata), 32'(exp_mem[idx]));
        check("tlast", 32'(m_axis_tlast), 32'((idx % FL) == FL - 1));
        check("xfer_count", 32'(xfer_count), idx);
        $display("xfer %0d data %04h last %0d", idx, m_axis_tdata, m_axis_tlast);
        idx++;
        if (idx == SAMP) seen_last = 1;
      end
      stall   = m_axis_tvalid && !m_axis_tready;
      hold_d  = m_axis_tdata;
      hold_l  = m_axis_tlast;
      wr_prev = wr_en;
      tick();
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        wr_en = 1'b0; start = 1'b0;
        async_reset("abort");
        finished = 1;
        break;
      end
    end
    wr_en = 1'b0; start = 1'b0;
    if (!finished) begin
      n_cmp++; n_err++;
      $display("FAIL pass_timeout: got %0d samples required %0d", idx, SAMP);
    end
    $display("pass duty %0d: %0d samples in %0d cycles", duty, idx, cyc);
  endtask

  vec_t tbl [12];

  initial begin
    int idx;
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 1, 1, 0, 1, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 1, 2, 0, 1, 0, 0, 2};
    tbl[7]  = '{1, 1, 0, 1, 3, 0, 1, 0, 0, 3};
    tbl[8]  = '{0, 1, 0, 1, 4, 0, 1, 0, 0, 4};
    tbl[9]  = '{0, 1, 0, 1, 5, 0, 1, 0, 0, 5};
    tbl[10] = '{0, 0, 0, 1, 5, 0, 1, 0, 0, 5};
    tbl[11] = '{0, 1, 0, 1, 6, 0, 1, 0, 0, 6};

    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; m_axis_tready = 1'b0;
    #1;
    check_all_zero("reset");
    tick(); tick();
    rstn = 1'b1;
    tick();
    check_all_zero("post_reset");

    load_ram(1'b1);
    for (int r = 0; r < 12; r++) begin
      start = 1'(tbl[r].st); m_axis_tready = 1'(tbl[r].rdy); wr_en = 1'(tbl[r].wr);
      wr_addr = AW'(5); wr_data = 16'hBEEF;
      tick();
      check("tbl_tvalid", 32'(m_axis_tvalid), tbl[r].v);
      check("tbl_tdata", 32'(m_axis_tdata), tbl[r].d);
      check("tbl_tlast", 32'(m_axis_tlast), tbl[r].l);
      check("tbl_busy", 32'(busy), tbl[r].b);
      check("tbl_done", 32'(done), tbl[r].dn);
      check("tbl_wr_err", 32'(wr_err), tbl[r].e);
      check("tbl_xfer", 32'(xfer_count), tbl[r].x);
      $display("row %0d: valid %0d data %04h xfer %0d", r, m_axis_tvalid, m_axis_tdata, xfer_count);
    end
    start = 1'b0; wr_en = 1'b0;
    async_reset("mid_table");

`ifdef VIP_PLAYBACK_LOOP_EN
    load_ram(1'b0);
    start = 1'b1; m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 600; c++) begin
      check("loop_done", 32'(done), 0);
      if (c >= 2) check("loop_no_bubble", 32'(m_axis_tvalid), 1);
      if (m_axis_tvalid) begin
        check("loop_tdata", 32'(m_axis_tdata), 32'(exp_mem[idx % SAMP]));
        check("loop_tlast", 32'(m_axis_tlast), 32'((idx % FL) == FL - 1));
        check("loop_xfer", 32'(xfer_count), idx % SAMP);
        $display("xfer %0d data %04h last %0d", idx, m_axis_tdata, m_axis_tlast);
        idx++;
      end
      tick();
    end
    check("loop_count", idx, 598);
    async_reset("loop_end");
`else
    idx = 0;
    run_pass(100, -1, -1, -1);
    load_ram(1'b0);
    run_pass(100, -1, -1, -1);
    run_pass(50, -1, -1, -1);
    run_pass(50, 3, -1, -1);
    write_one(5, 16'hBEEF);
    run_pass(100, -1, -1, -1);
    run_pass(100, -1, 50, -1);
    run_pass(75, -1, -1, 100);
    run_pass(100, -1, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
